// File: rtl/vga_pkg.sv
// Shared timing defaults, text-grid geometry and pipeline types for the VGA text read path.
// Defaults describe 640x480@60 with an 80x25 grid of 8x16 glyphs.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;

  localparam int COLS_DEF       = 80;
  localparam int ROWS_DEF       = 25;
  localparam int FONT_H         = 16;
  localparam int GLYPH_W        = 8;
  localparam int TEXT_LINES     = ROWS_DEF * FONT_H;
  localparam int FETCH_LEAD     = 3;
  localparam int BLINK_LOG2_DEF = 4;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 11;
  localparam int CODE_W = 8;
  localparam int SCAN_W = 4;

  // One character fetch travelling down the RAM -> font -> shifter pipeline.
  typedef struct packed {
    logic              vld;
    logic [SCAN_W-1:0] scan;
    logic              cur;
  } fetch_t;

  typedef struct packed {
    logic vld;
    logic cur;
  } load_t;

  // row*cols + col as a sum of shifted rows over the set bits of cols (80 -> <<6 + <<4).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col,
                                                  input int                cols);
    logic [ADDR_W-1:0] acc;
    acc = col;
    for (int i = 0; i < ADDR_W; i++) begin
      if (cols[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Raster counters with combinational sync/active/frame-start decode and a blink frame counter.
// Decodes describe the current counter position; the caller registers them for alignment.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int BLINK_LOG2 = BLINK_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_first,
  output logic             blink
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic [CNT_W-1:0]    vcnt_q, vcnt_d;
  logic [BLINK_LOG2:0] frame_q, frame_d;

  always_comb begin
    hcnt_d  = hcnt_q + 1'b1;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d  = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    hcnt        = hcnt_q;
    vcnt        = vcnt_q;
    active      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hsync_n     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vsync_n     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    frame_first = (hcnt_q == '0) && (vcnt_q == '0);
    blink       = frame_q[BLINK_LOG2];
  end

endmodule

// File: rtl/vga_text_fetch.sv
// Text-mode pixel engine: fetches char codes and glyph rows ahead of the beam, serialises pixels
// with a blinking underline cursor; every output is registered and appears 1 clk after its hcnt.
module vga_text_fetch
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int BLINK_LOG2 = BLINK_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ram_cs,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [CODE_W-1:0]        ram_rdata,
  output logic [CODE_W+SCAN_W-1:0] font_addr,
  input  logic [GLYPH_W-1:0]       font_data,
  input  logic [ADDR_W-1:0]        cursor_pos,
  input  logic                     cursor_en,
  output logic                     pix,
  output logic                     video_on,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // ram_cs is itself a flop, so the fetch decision is made one pixel before the F0 cycle.
  localparam logic [CNT_W-1:0]  LEAD      = CNT_W'(FETCH_LEAD + 1);
  localparam logic [CNT_W-1:0]  H_LA_WRAP = CNT_W'(H_TOTAL - FETCH_LEAD - 1);
  localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  TEXT_PIX  = CNT_W'(COLS * GLYPH_W);
  localparam logic [CNT_W-1:0]  TEXT_LN   = CNT_W'(ROWS * FONT_H);
  localparam logic [SCAN_W-1:0] CUR_SCAN  = SCAN_W'(FONT_H - 2);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             active, hsync_n, vsync_n, frame_first, blink;

  vga_sync_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .BLINK_LOG2 (BLINK_LOG2)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active      (active),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_first (frame_first),
    .blink       (blink)
  );

  logic [CNT_W-1:0]          la_h, la_v;
  logic                      fetch_hit;
  logic [ADDR_W-1:0]         fetch_addr;
  fetch_t                    st_a_q, st_a_d, st_b_q, st_b_d;
  load_t                     st_c_q, st_c_d, st_d_q, st_d_d;
  logic [ADDR_W-1:0]         ram_addr_q, ram_addr_d;
  logic [CODE_W+SCAN_W-1:0]  font_addr_q, font_addr_d;
  logic [GLYPH_W-1:0]        glyph;
  logic [GLYPH_W-1:0]        shreg_q, shreg_d;
  logic                      pix_q, pix_d;
  logic                      video_q, hsync_q, vsync_q, fs_q;

  // Beam position FETCH_LEAD+1 pixels ahead; crossing the line end moves to the next line.
  always_comb begin
    la_h = hcnt + LEAD;
    la_v = vcnt;
    if (hcnt >= H_LA_WRAP) begin
      la_h = hcnt - H_LA_WRAP;
      la_v = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end
  end

  always_comb begin
    fetch_hit  = (la_h < TEXT_PIX) && (la_h[2:0] == 3'd0) && (la_v < TEXT_LN);
    fetch_addr = cell_addr(ADDR_W'(la_v[CNT_W-1:SCAN_W]), ADDR_W'(la_h[CNT_W-1:3]), COLS);

    st_a_d.vld  = fetch_hit;
    st_a_d.scan = la_v[SCAN_W-1:0];
    st_a_d.cur  = fetch_hit && cursor_en && (fetch_addr == cursor_pos) &&
                  (la_v[SCAN_W-1:0] >= CUR_SCAN) && blink;
    ram_addr_d  = fetch_hit ? fetch_addr : ram_addr_q;

    st_b_d      = st_a_q;
    font_addr_d = st_b_q.vld ? {ram_rdata, st_b_q.scan} : font_addr_q;

    st_c_d.vld  = st_b_q.vld;
    st_c_d.cur  = st_b_q.cur;
    st_d_d      = st_c_q;

    glyph = font_data ^ {GLYPH_W{st_d_q.cur}};
    if (st_d_q.vld) begin
      pix_d   = glyph[GLYPH_W-1];
      shreg_d = {glyph[GLYPH_W-2:0], 1'b0};
    end else begin
      pix_d   = shreg_q[GLYPH_W-1];
      shreg_d = {shreg_q[GLYPH_W-2:0], 1'b0};
    end
    pix_d = pix_d && active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_a_q      <= '0;
      st_b_q      <= '0;
      st_c_q      <= '0;
      st_d_q      <= '0;
      ram_addr_q  <= '0;
      font_addr_q <= '0;
      shreg_q     <= '0;
      pix_q       <= 1'b0;
      video_q     <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      st_a_q      <= st_a_d;
      st_b_q      <= st_b_d;
      st_c_q      <= st_c_d;
      st_d_q      <= st_d_d;
      ram_addr_q  <= ram_addr_d;
      font_addr_q <= font_addr_d;
      shreg_q     <= shreg_d;
      pix_q       <= pix_d;
      video_q     <= active;
      hsync_q     <= hsync_n;
      vsync_q     <= vsync_n;
      fs_q        <= frame_first;
    end
  end

  always_comb begin
    ram_cs      = st_a_q.vld;
    ram_addr    = ram_addr_q;
    font_addr   = font_addr_q;
    pix         = pix_q;
    video_on    = video_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    frame_start = fs_q;
  end

endmodule
